// File: rtl/board_arbiter_if.sv
// ---------------------------------------------------------------------------
// board_arbiter_if
// Falling-piece movement handshake between a piece controller (master) and
// the board arbiter (slave).
//   movement_request    master -> slave  level; proposed position valid while high
//   movement_intent     master -> slave  0 = natural fall, 1 = player move/rotate
//   p1blk_v..p4blk_v    master -> slave  proposed block columns
//   p1blk_h..p4blk_h    master -> slave  proposed block rows
//   volatile_blk_color  master -> slave  colour of the falling piece
//   movement_commit     slave -> master  1-cycle pulse, move accepted
//   movement_declined   slave -> master  level, move rejected until request drops
//   movement_steal      slave -> master  level, piece locked until request drops
// ---------------------------------------------------------------------------
interface board_arbiter_if;
    logic       movement_request;
    logic       movement_intent;
    logic [4:0] p1blk_v;
    logic [4:0] p2blk_v;
    logic [4:0] p3blk_v;
    logic [4:0] p4blk_v;
    logic [4:0] p1blk_h;
    logic [4:0] p2blk_h;
    logic [4:0] p3blk_h;
    logic [4:0] p4blk_h;
    logic [2:0] volatile_blk_color;
    logic       movement_commit;
    logic       movement_declined;
    logic       movement_steal;

    modport master (
        output movement_request, movement_intent,
        output p1blk_v, p2blk_v, p3blk_v, p4blk_v,
        output p1blk_h, p2blk_h, p3blk_h, p4blk_h,
        output volatile_blk_color,
        input  movement_commit, movement_declined, movement_steal
    );

    modport slave (
        input  movement_request, movement_intent,
        input  p1blk_v, p2blk_v, p3blk_v, p4blk_v,
        input  p1blk_h, p2blk_h, p3blk_h, p4blk_h,
        input  volatile_blk_color,
        output movement_commit, movement_declined, movement_steal
    );
endinterface

// File: rtl/board_arbiter.sv
// ---------------------------------------------------------------------------
// board_arbiter
// Owns the locked-cell board. Each movement request is checked against the
// board bounds and the locked cells and answered with commit, decline or
// steal. A steal first locks the previously committed piece into the board
// and collapses every full row. A registered read port serves the renderer.
//   clk            system clock
//   reset          synchronous, active-high reset
//   bus            movement handshake (slave side)
//   rd_h, rd_v     renderer read address
//   rd_color       colour at (rd_h, rd_v), one cycle later; 0 = empty/out of range
//   lines_cleared  number of collapsed rows, wraps at 255
//   game_over      sticky; a freshly spawned piece could not fall
// ---------------------------------------------------------------------------
module board_arbiter #(
    parameter int ROWS = 20,
    parameter int COLS = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    board_arbiter_if.slave       bus,
    input  logic [4:0]           rd_h,
    input  logic [4:0]           rd_v,
    output logic [2:0]           rd_color,
    output logic [7:0]           lines_cleared,
    output logic                 game_over
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_COMMIT,
        S_DECLINE,
        S_LOCK,
        S_SCAN,
        S_STEAL,
        S_RELEASE
    } state_t;

    state_t     state;
    state_t     state_next;

    logic [2:0] board [ROWS][COLS];

    logic [4:0] req_h [4];
    logic [4:0] req_v [4];
    logic       req_intent;
    logic [2:0] req_color;

    logic [4:0] last_h [4];
    logic [4:0] last_v [4];
    logic       last_valid;

    logic [4:0] scan_row;

    logic [3:0] blocked;
    logic       hit;
    logic       row_full;
    logic       rd_in_range;
    logic [2:0] lock_color;

    // A block is blocked when it lies outside the board (5-bit wrap-around
    // lands outside too) or when its cell already holds a colour.
    always_comb begin
        blocked = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            if (req_h[2'(i)] < 5'(ROWS) && req_v[2'(i)] < 5'(COLS)) begin
                blocked[2'(i)] = (board[RW'(req_h[2'(i)])][CW'(req_v[2'(i)])] != 3'b000);
            end
        end
    end

    assign hit = |blocked;

    // The row under test during SCAN is full when no cell is empty.
    always_comb begin
        row_full = 1'b1;
        for (int c = 0; c < COLS; c++) begin
            if (board[RW'(scan_row)][CW'(c)] == 3'b000) begin
                row_full = 1'b0;
            end
        end
    end

    assign rd_in_range = (rd_h < 5'(ROWS)) && (rd_v < 5'(COLS));

    // Colour 0 would read back as empty, so it is replaced by a visible one.
    assign lock_color = (req_color == 3'b000) ? 3'b101 : req_color;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus the Moore handshake outputs. A stale request
    // left high after a commit is parked in RELEASE so it is never re-checked.
    always_comb begin
        state_next            = state;
        bus.movement_commit   = 1'b0;
        bus.movement_declined = 1'b0;
        bus.movement_steal    = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.movement_request && !game_over) begin
                    state_next = S_CHECK;
                end
            end
            S_CHECK: begin
                if (!hit) begin
                    state_next = S_COMMIT;
                end else if (req_intent) begin
                    state_next = S_DECLINE;
                end else if (last_valid) begin
                    state_next = S_LOCK;
                end else begin
                    state_next = S_DECLINE;
                end
            end
            S_COMMIT: begin
                bus.movement_commit = 1'b1;
                state_next          = S_RELEASE;
            end
            S_DECLINE: begin
                bus.movement_declined = 1'b1;
                if (!bus.movement_request) begin
                    state_next = S_IDLE;
                end
            end
            S_LOCK: begin
                state_next = S_SCAN;
            end
            S_SCAN: begin
                if (!row_full && scan_row == 5'd0) begin
                    state_next = S_STEAL;
                end
            end
            S_STEAL: begin
                bus.movement_steal = 1'b1;
                if (!bus.movement_request) begin
                    state_next = S_IDLE;
                end
            end
            S_RELEASE: begin
                if (!bus.movement_request) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Datapath: request latch, last committed position, the board itself,
    // the row scanner and the renderer read port. The read port samples the
    // board before this edge's writes, so it may show pre-collapse contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    board[RW'(r)][CW'(c)] <= 3'b000;
                end
            end
            for (int i = 0; i < 4; i++) begin
                req_h[2'(i)]  <= 5'd0;
                req_v[2'(i)]  <= 5'd0;
                last_h[2'(i)] <= 5'd0;
                last_v[2'(i)] <= 5'd0;
            end
            req_intent    <= 1'b0;
            req_color     <= 3'b000;
            last_valid    <= 1'b0;
            scan_row      <= 5'd0;
            lines_cleared <= 8'd0;
            game_over     <= 1'b0;
            rd_color      <= 3'b000;
        end else begin
            rd_color <= rd_in_range ? board[RW'(rd_h)][CW'(rd_v)] : 3'b000;
            case (state)
                S_IDLE: begin
                    if (bus.movement_request && !game_over) begin
                        req_h[0]   <= bus.p1blk_h;
                        req_h[1]   <= bus.p2blk_h;
                        req_h[2]   <= bus.p3blk_h;
                        req_h[3]   <= bus.p4blk_h;
                        req_v[0]   <= bus.p1blk_v;
                        req_v[1]   <= bus.p2blk_v;
                        req_v[2]   <= bus.p3blk_v;
                        req_v[3]   <= bus.p4blk_v;
                        req_intent <= bus.movement_intent;
                        req_color  <= bus.volatile_blk_color;
                    end
                end
                S_CHECK: begin
                    if (hit && !req_intent && !last_valid) begin
                        game_over <= 1'b1;
                    end
                end
                S_COMMIT: begin
                    last_h     <= req_h;
                    last_v     <= req_v;
                    last_valid <= 1'b1;
                end
                S_LOCK: begin
                    for (int i = 0; i < 4; i++) begin
                        board[RW'(last_h[2'(i)])][CW'(last_v[2'(i)])] <= lock_color;
                    end
                    last_valid <= 1'b0;
                    scan_row   <= 5'(ROWS - 1);
                end
                S_SCAN: begin
                    // A full row is overwritten by everything above it and
                    // the same row is tested again, since the row that drops
                    // into it may be full as well.
                    if (row_full) begin
                        for (int r = ROWS - 1; r > 0; r--) begin
                            if (5'(r) <= scan_row) begin
                                board[RW'(r)] <= board[RW'(r - 1)];
                            end
                        end
                        board[0]      <= '{default: 3'b000};
                        lines_cleared <= lines_cleared + 8'd1;
                    end else if (scan_row != 5'd0) begin
                        scan_row <= scan_row - 5'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
